// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg: shared types and helpers for the bus encoding-mode scheduler
// Holds the encoding-mode enum, the scheduler FSM state type, popcount8 and gray8.
package enc_sched_pkg;
  typedef enum logic [1:0] {MODE_NORM, MODE_GRAY, MODE_INV, MODE_T0} enc_mode_t;
  typedef enum logic [1:0] {MEASURE, DECIDE, SWITCH} sched_state_t;
  function automatic logic [3:0] popcount8(input logic [7:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n += {3'b0, x[i]};
    return n;
  endfunction
  function automatic logic [7:0] gray8(input logic [7:0] x);
    return x ^ (x >> 1);
  endfunction
endpackage

// File: rtl/bus_enc_sched_if.sv
// bus_enc_sched_if: data-stream and switch-handshake bundle of the encoding scheduler
// Ports: din/din_valid/din_ready (source handshake), mode (committed encoding),
// sw_req/sw_mode/sw_ack (switch handshake to the encoder/decoder pair),
// win_done (decision pulse), best_cost (winning cost of the last window).
// Modports: master = data source and encoder side, slave = scheduler.
interface bus_enc_sched_if #(parameter int ACC_W = 10);
  logic [7:0] din;
  logic din_valid;
  logic din_ready;
  logic [1:0] mode;
  logic sw_req;
  logic [1:0] sw_mode;
  logic sw_ack;
  logic win_done;
  logic [ACC_W-1:0] best_cost;
  modport master(output din, din_valid, sw_ack, input din_ready, mode, sw_req, sw_mode, win_done, best_cost);
  modport slave(input din, din_valid, sw_ack, output din_ready, mode, sw_req, sw_mode, win_done, best_cost);
endinterface

// File: rtl/enc_cost_calc.sv
// enc_cost_calc: per-word switching cost of each encoding plus the bus history it needs
// Ports: ck, rst (async, active-high), d (current word), acc_en (word accepted,
// advance history), cost[m] (cost of word d under mode m: NORM, GRAY, INV, T0).
// History (previous word, bus-invert bus, T0 bus/inc, first flag) is cleared only by rst.
module enc_cost_calc
  import enc_sched_pkg::*;
#(
  parameter int STRIDE = 1
) (
  input  logic ck,
  input  logic rst,
  input  logic [7:0] d,
  input  logic acc_en,
  output logic [3:0][3:0] cost
);
  logic [7:0] p, tb, tb_new, p_next;
  logic [8:0] bi, bi_new;
  logic inc, first, hit;
  always_comb begin
    p_next = p + 8'(STRIDE);
    hit = !first && d == p_next;
    tb_new = hit ? tb : d;
    bi_new = popcount8(d ^ bi[7:0]) > 4'd4 ? {1'b1, ~d} : {1'b0, d};
    cost[0] = popcount8(d ^ p);
    cost[1] = popcount8(gray8(d) ^ gray8(p));
    cost[2] = popcount8(bi_new[7:0] ^ bi[7:0]) + {3'b0, bi_new[8] ^ bi[8]};
    cost[3] = popcount8(tb_new ^ tb) + {3'b0, hit ^ inc};
  end
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      p <= '0;
      bi <= '0;
      tb <= '0;
      inc <= 1'b0;
      first <= 1'b1;
    end else if (acc_en) begin
      p <= d;
      bi <= bi_new;
      tb <= tb_new;
      inc <= hit;
      first <= 1'b0;
    end
endmodule

// File: rtl/bus_enc_sched.sv
// bus_enc_sched: windowed adaptive encoding-mode scheduler with switch handshake
// Ports: ck, rst (async, active-high), bus (bus_enc_sched_if.slave: din stream,
// committed mode, sw_req/sw_mode/sw_ack handshake, win_done pulse, best_cost).
// Optional feature: define ENC_SCHED_HYST_EN to switch only when the winner beats
// the current mode by more than HYST; otherwise any different winner switches.
module bus_enc_sched
  import enc_sched_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int ACC_W = 10,
  parameter int STRIDE = 1,
  parameter int HYST = 8
) (
  input logic ck,
  input logic rst,
  bus_enc_sched_if.slave bus
);
  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  if (WINDOW < 2 || HYST < 0) begin : g_bad_cfg
    $error("bus_enc_sched: WINDOW must be >= 2 and HYST >= 0");
  end
  sched_state_t state, state_nx;
  enc_mode_t mode_q, sw_mode_q, best;
  logic sw_req_q, accept, switch_needed;
  logic [3:0][3:0] cost;
  logic [ACC_W-1:0] acc [4];
  logic [ACC_W-1:0] best_cost_q;
  logic [CNT_W-1:0] cnt;
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [3:0] c);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(c);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction
  enc_cost_calc #(.STRIDE(STRIDE)) u_cost (
    .ck(ck),
    .rst(rst),
    .d(bus.din),
    .acc_en(accept),
    .cost(cost)
  );
  // strict < keeps ties on the lowest mode index
  always_comb begin
    best = MODE_NORM;
    best = acc[1] < acc[best] ? MODE_GRAY : best;
    best = acc[2] < acc[best] ? MODE_INV : best;
    best = acc[3] < acc[best] ? MODE_T0 : best;
  end
`ifdef ENC_SCHED_HYST_EN
  localparam logic [ACC_W:0] MARGIN = (ACC_W+1)'(HYST);
  always_comb switch_needed = {1'b0, acc[best]} + MARGIN < {1'b0, acc[mode_q]};
`else
  always_comb switch_needed = best != mode_q;
`endif
  always_ff @(posedge ck or posedge rst)
    if (rst) state <= MEASURE;
    else state <= state_nx;
  always_comb begin
    accept = bus.din_valid && state == MEASURE;
    state_nx = state == MEASURE ? (accept && cnt == LAST ? DECIDE : MEASURE)
             : state == DECIDE ? (switch_needed ? SWITCH : MEASURE)
             : (bus.sw_ack ? MEASURE : SWITCH);
  end
  always_ff @(posedge ck or posedge rst)
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      best_cost_q <= '0;
      mode_q <= MODE_NORM;
      sw_mode_q <= MODE_NORM;
      sw_req_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= cnt + 1'b1;
        for (int i = 0; i < 4; i++) acc[i] <= sat_add(acc[i], cost[i]);
      end
      if (state == DECIDE) begin
        cnt <= '0;
        for (int i = 0; i < 4; i++) acc[i] <= '0;
        best_cost_q <= acc[best];
        if (switch_needed) begin
          sw_mode_q <= best;
          sw_req_q <= 1'b1;
        end
      end
      if (state == SWITCH && bus.sw_ack) begin
        mode_q <= sw_mode_q;
        sw_req_q <= 1'b0;
      end
    end
  assign bus.din_ready = state == MEASURE;
  assign bus.win_done = state == DECIDE;
  assign bus.mode = mode_q;
  assign bus.sw_mode = sw_mode_q;
  assign bus.sw_req = sw_req_q;
  assign bus.best_cost = best_cost_q;
endmodule

// File: tb/tb_bus_enc_sched.sv
// tb_bus_enc_sched: directed-vector self-checking bench for bus_enc_sched
module tb_bus_enc_sched;
  logic ck = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  bus_enc_sched_if #(.ACC_W(10)) sb ();
  bus_enc_sched #(.WINDOW(64), .ACC_W(10), .STRIDE(1), .HYST(8)) dut (
    .ck(ck),
    .rst(rst),
    .bus(sb)
  );
  always #5 ck = ~ck;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pat(input int kind, input int i);
    logic [31:0] v;
    v = i;
    return kind == 0 ? v[7:0] : kind == 1 ? 8'hA5 : kind == 2 ? (v[0] ? 8'hFF : 8'h00) : (i == 1 ? 8'h03 : 8'h00);
  endfunction
  task automatic do_reset();
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
  endtask
  // feeds 64 back-to-back words, returns at the negedge inside DECIDE
  task automatic run_window(input int kind, input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge ck);
      if (i == 63) check({tag, "_win_early"}, sb.win_done, 0);
      sb.din = pat(kind, i);
      sb.din_valid = 1'b1;
    end
    @(negedge ck);
    sb.din_valid = 1'b0;
    check({tag, "_win_done"}, sb.win_done, 1);
    check({tag, "_ready_decide"}, sb.din_ready, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic early;
    sb.din = '0;
    sb.din_valid = 1'b0;
    sb.sw_ack = 1'b0;
    #2;
    check("rst_mode", sb.mode, 0);
    check("rst_sw_req", sb.sw_req, 0);
    check("rst_sw_mode", sb.sw_mode, 0);
    check("rst_din_ready", sb.din_ready, 1);
    check("rst_win_done", sb.win_done, 0);
    check("rst_best_cost", sb.best_cost, 0);
    @(negedge ck);
    rst = 1'b0;
    sb.sw_ack = 1'b1;
    run_window(0, "inc");
    @(negedge ck);
    check("inc_sw_req", sb.sw_req, 1);
    check("inc_sw_mode", sb.sw_mode, 3);
    check("inc_ready_sw", sb.din_ready, 0);
    check("inc_mode_old", sb.mode, 0);
    check("inc_win_low", sb.win_done, 0);
    @(negedge ck);
    check("inc_mode", sb.mode, 3);
    check("inc_ready", sb.din_ready, 1);
    check("inc_sw_req_drop", sb.sw_req, 0);
    check("inc_best_cost", sb.best_cost, 1);
    sb.sw_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      sb.din = pat(0, i);
      sb.din_valid = 1'b1;
    end
    @(negedge ck);
    sb.din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midwin_rst_mode", sb.mode, 0);
    check("midwin_rst_ready", sb.din_ready, 1);
    @(negedge ck);
    rst = 1'b0;
    run_window(0, "inc2");
    @(negedge ck);
    check("inc2_sw_req", sb.sw_req, 1);
    check("inc2_sw_mode", sb.sw_mode, 3);
    sb.sw_ack = 1'b1;
    @(negedge ck);
    check("inc2_mode", sb.mode, 3);
    check("inc2_best_cost", sb.best_cost, 1);
    do_reset();
    run_window(1, "const");
    @(negedge ck);
    check("const_sw_req", sb.sw_req, 0);
    check("const_ready", sb.din_ready, 1);
    check("const_mode", sb.mode, 0);
    check("const_best_cost", sb.best_cost, 4);
    sb.sw_ack = 1'b0;
    do_reset();
    run_window(2, "alt");
    @(negedge ck);
    check("alt_best_cost", sb.best_cost, 63);
    for (int k = 0; k < 5; k++) begin
      check("alt_sw_req_hold", sb.sw_req, 1);
      check("alt_sw_mode_hold", sb.sw_mode, 1);
      check("alt_ready_hold", sb.din_ready, 0);
      check("alt_mode_hold", sb.mode, 0);
      @(negedge ck);
    end
    sb.sw_ack = 1'b1;
    @(posedge ck);
    #1;
    check("alt_mode", sb.mode, 1);
    check("alt_ready", sb.din_ready, 1);
    check("alt_sw_req_drop", sb.sw_req, 0);
    @(negedge ck);
    sb.sw_ack = 1'b0;
    do_reset();
    run_window(3, "hyst");
    @(negedge ck);
    check("hyst_best_cost", sb.best_cost, 2);
`ifdef ENC_SCHED_HYST_EN
    check("hyst_sw_req", sb.sw_req, 0);
    check("hyst_ready", sb.din_ready, 1);
    check("hyst_mode", sb.mode, 0);
`else
    check("hyst_sw_req", sb.sw_req, 1);
    check("hyst_sw_mode", sb.sw_mode, 1);
    sb.sw_ack = 1'b1;
    @(negedge ck);
    check("hyst_mode", sb.mode, 1);
    sb.sw_ack = 1'b0;
`endif
    do_reset();
    early = 1'b0;
    for (int i = 0; i < 127; i++) begin
      @(negedge ck);
      if (sb.win_done) early = 1'b1;
      sb.din = 8'hA5;
      sb.din_valid = (i % 2) == 0;
    end
    @(negedge ck);
    sb.din_valid = 1'b0;
    check("gap_win_early", early, 0);
    check("gap_win_done", sb.win_done, 1);
    @(negedge ck);
    check("gap_ready", sb.din_ready, 1);
    check("gap_best_cost", sb.best_cost, 4);
    do_reset();
    run_window(0, "rsw");
    @(negedge ck);
    check("rsw_sw_req", sb.sw_req, 1);
    #2 rst = 1'b1;
    #1;
    check("rsw_sw_req_rst", sb.sw_req, 0);
    check("rsw_ready_rst", sb.din_ready, 1);
    check("rsw_mode_rst", sb.mode, 0);
    check("rsw_sw_mode_rst", sb.sw_mode, 0);
    check("rsw_best_cost_rst", sb.best_cost, 0);
    @(negedge ck);
    rst = 1'b0;
    run_window(0, "rsw2");
    @(negedge ck);
    check("rsw2_sw_req", sb.sw_req, 1);
    check("rsw2_sw_mode", sb.sw_mode, 3);
    sb.sw_ack = 1'b1;
    @(negedge ck);
    check("rsw2_mode", sb.mode, 3);
    check("rsw2_best_cost", sb.best_cost, 1);
    sb.sw_ack = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_enc_sched.md
# bus_enc_sched

Adaptive encoding-mode scheduler for the 8-bit low-power bus encoders (normal, Gray, bus-invert, T0).

- Observes the raw data stream and computes, per word, the exact switching cost each encoding would incur on its bus.
- Accumulates those costs over a fixed window of accepted words.
- At each window boundary, picks the cheapest scheme and hands it to the encoder/decoder pair through a request/acknowledge switch handshake.
- Sits in front of the encoder bank; stalls the data source while a decision or switch is in progress.

## Interface

Parameters:
- WINDOW, 64: accepted words per measurement window (≥2).
- ACC_W, 10: cost accumulator width; accumulators saturate at 2^ACC_W−1.
- STRIDE, 1: T0 sequential stride; addition is mod 256.
- HYST, 8: hysteresis margin, used only with ENC_SCHED_HYST_EN.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset rst, asynchronous, active-high.
- din  in  8  raw data word.
- din_valid  in  1  din valid.
- din_ready  out  1  scheduler accepts din; a word is accepted when din_valid & din_ready at a posedge.
- mode  out  2  committed encoding: 0 NORM, 1 GRAY, 2 INV, 3 T0.
- sw_req  out  2→1  switch request to encoder/decoder pair (1 bit).
- sw_mode  out  2  requested mode; stable while sw_req=1.
- sw_ack  in  1  encoder/decoder pair has switched.
- win_done  out  1  one-cycle pulse at each window decision.
- best_cost  out  ACC_W  winning accumulated cost of the last window.

## Operation

Per accepted word d, with p = previous accepted word (reset 0):

- **NORM cost** = popcount(d^p).
- **GRAY cost** = popcount(g(d)^g(p)), where g(x) = x^(x>>1).
- **INV cost**
  - State bi[8:0], reset 0.
  - h = popcount(d^bi[7:0]).
  - New bus = {1,~d} if h>4, else {0,d}.
  - Cost = popcount(new^bi); bi ← new.
- **T0 cost**
  - State tb[7:0] and inc, both reset 0; flag first, reset 1.
  - If !first and d == p+STRIDE: bus held, inc'=1.
  - Otherwise: tb ← d, inc'=0.
  - Cost = popcount(tb_new^tb_old) + (inc'^inc).
  - first clears after the first accepted word.
- **History persistence:** p, bi, tb, inc and first persist across windows; they are cleared only by rst.
- **Accumulators:** four ACC_W-bit saturating accumulators plus a word counter of width $clog2(WINDOW).

FSM states: MEASURE, DECIDE, SWITCH.

- **MEASURE**
  - din_ready=1.
  - Each accepted word adds its four costs and increments the counter.
  - The WINDOW-th accept moves the FSM to DECIDE.
- **DECIDE** (exactly 1 cycle)
  - din_ready=0; win_done=1.
  - best = minimum accumulator; ties go to the lowest mode index.
  - best_cost is registered.
  - If a switch is required: go to SWITCH, with sw_mode←best and sw_req←1.
  - Otherwise: go to MEASURE.
  - Accumulators and counter clear on leaving DECIDE.
- **SWITCH**
  - din_ready=0; sw_req held high and sw_mode held stable.
  - The edge that samples sw_ack=1 sets mode←sw_mode and sw_req←0, and returns the FSM to MEASURE.
  - There is no timeout.

## Timing

- **Reset values:** mode=0, sw_req=0, sw_mode=0, din_ready=1, win_done=0, best_cost=0, FSM=MEASURE, all accumulators/counters/history 0, first=1.
- **Decision latency:** win_done is high in the cycle after the WINDOW-th accept.
- **Switch request:** sw_req rises at the edge ending DECIDE.
- **Mode update:** mode changes at the edge sampling sw_ack=1, and din_ready rises at that same edge.
- **Minimum stall:** 1 cycle without a switch; 2 cycles with a switch when sw_ack is already high.
- **Stale acknowledge:** sw_ack is ignored outside SWITCH.
- **din_valid gaps:** extend the window; only accepted words count.
- **rst mid-window or mid-SWITCH:** immediate return to reset values; a pending request is dropped.
- **Saturation:** a saturated accumulator holds its value; the comparison uses the saturated values.

## Configuration

- **ENC_SCHED_HYST_EN defined:** switch only if acc[best] + HYST < acc[mode]. The sum is computed at ACC_W+1 bits.
- **ENC_SCHED_HYST_EN undefined:** switch whenever best ≠ mode. HYST is unused.

## Structure

- **Shared package enc_sched_pkg:**
  - mode enum (MODE_NORM=0, MODE_GRAY=1, MODE_INV=2, MODE_T0=3);
  - FSM state typedef;
  - popcount8 and gray8 functions.
- **Sub-module enc_cost_calc:** combinational per-word costs plus the bi/tb/inc/p/first history registers. It has a single instance inside bus_enc_sched, which holds the FSM, the accumulators and the handshake.

## Test plan

Defaults apply unless stated; HYST_EN defined.

- **Incrementing data:** din 0..63 after reset → NORM=120, T0=1; win_done pulse, sw_mode=3, sw_req=1; sw_ack=1 → mode=3, best_cost=1.
- **Constant data:** 0xA5 ×64 → NORM=4, INV=4, GRAY=7, T0=4; best_cost=4, no sw_req, mode stays 0.
- **Alternating data with delayed ack:** 0x00/0xFF alternating ×64 → GRAY=63, INV=63; tie picks sw_mode=1. Hold sw_ack=0 for 5 cycles → sw_req and sw_mode stable, din_ready=0, mode=0. Then ack → mode=1 at that edge, din_ready=1.
- **Hysteresis margin:** 0x00, 0x03, then 0x00 ×62 → NORM=4, GRAY=2. With HYST_EN: no switch. Without HYST_EN: switch to GRAY.
- **Valid gaps:** din_valid toggling every cycle → win_done only after the 64th accepted word.
- **Reset mid-SWITCH:** assert rst during SWITCH → sw_req=0, mode=0, din_ready=1 asynchronously; the next window starts with first=1.
